// File: rtl/fetch_unit.sv
// fetch_unit: two-byte instruction fetcher with a program counter and an issue handshake.
// Each instruction is read high byte first, then low byte. The unit holds the result in
// ISSUE until the decode stage takes it, and then either jumps or continues sequentially.
// Optional feature macro: FETCH_HALT_EN. When it is defined, issuing opcode 4'hF parks
// the unit in HALT until the next reset.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  input  logic        jmp_enable,
  output logic [7:0]  pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    ISSUE    = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t state, state_next;
  logic   handshake;
  logic   halt_op;

  assign handshake = (state == ISSUE) && instr_ready;
  assign opcode    = instr[15:12];
  assign mem_addr  = pc;

`ifdef FETCH_HALT_EN
  assign halt_op = (instr[15:12] == 4'hF);
`else
  assign halt_op = 1'b0;
`endif

  // State register; reset wins over any pending ack or handshake
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_HI;
    else     state <= state_next;
  end

  // Next-state logic: fetch states wait indefinitely for mem_ack, ISSUE waits for instr_ready
  always_comb begin
    state_next = state;
    case (state)
      FETCH_HI: if (mem_ack) state_next = FETCH_LO;
      FETCH_LO: if (mem_ack) state_next = ISSUE;
      ISSUE:    if (instr_ready) state_next = halt_op ? HALT : FETCH_HI;
      HALT:     state_next = HALT;
      default:  state_next = FETCH_HI;
    endcase
  end

  // Output decode: memory is only requested while a byte is outstanding
  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH_HI, FETCH_LO: mem_req = 1'b1;
      ISSUE:              instr_valid = 1'b1;
`ifdef FETCH_HALT_EN
      HALT:               halted = 1'b1;
`endif
      default: ;
    endcase
  end

  // Datapath: capture bytes on acks and advance or redirect the PC (8-bit wraparound)
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= 16'h0000;
    end else begin
      case (state)
        FETCH_HI: if (mem_ack) begin
          instr[15:8] <= mem_rdata;
          pc          <= pc + 8'd1;
        end
        FETCH_LO: if (mem_ack) begin
          instr[7:0] <= mem_rdata;
          pc         <= pc + 8'd1;
        end
        ISSUE: if (handshake && jmp_enable && !halt_op) pc <= instr[7:0];
        default: ;
      endcase
    end
  end

endmodule
